// File: rtl/periph_defines.sv
// Shared MMIO peripheral definitions: UART register offsets, STATUS/CTRL bit
// positions and the serial FSM state type used by both UART directions.
package periph_defines;

  localparam logic [11:0] UART_TXDATA_OFF  = 12'h000;
  localparam logic [11:0] UART_RXDATA_OFF  = 12'h004;
  localparam logic [11:0] UART_STATUS_OFF  = 12'h008;
  localparam logic [11:0] UART_CTRL_OFF    = 12'h00C;
  localparam logic [11:0] UART_BAUDDIV_OFF = 12'h010;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_BUSY    = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_TX_DROP    = 7;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_TX_IRQ_EN = 3;
  localparam int CTRL_LOOPBACK  = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full succeeds only
// when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and a level interrupt.
// Optional internal loopback (CTRL[4]) is built when UART_LOOPBACK_EN is defined.
module uart_mmio_periph
  import periph_defines::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867,
  parameter int          ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // mmio handshake: an access is accepted in any cycle where mmio_valid is
  // high (mmio_ready is always 1); read data is valid the following cycle.
  input  logic              mmio_valid,
  input  logic              mmio_we,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [31:0]       mmio_wdata,
  input  logic [3:0]        mmio_wstrb,
  output logic              mmio_ready,
  output logic [31:0]       mmio_rdata,
  input  logic              uart_rxd,
  output logic              uart_txd,
  output logic              irq,
  output logic [1:0]        tx_state_dbg,
  output logic [1:0]        rx_state_dbg
);

  logic [11:0] off;
  logic        wr_acc, rd_acc, w1c;
  logic [3:0]  ctrl_r;
  logic        lb_bit;
  logic [15:0] baud_div;
  logic        rx_overrun, frame_err, tx_drop;
  logic [31:0] rd_val;
  logic [7:0]  status_v;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_rdata;

  uart_state_e tx_state, tx_next, rx_state, rx_next;
  logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_sh, rx_sh;
  logic        tx_go, tx_bit_end, txd_int, rx_src;
  logic        rx_s1, rx_s2, rx_s3, rx_go, rx_samp, rx_shift, frame_set;
  logic        unused_bits;

  assign unused_bits = ^{mmio_addr[ADDR_W-1:12], mmio_wdata[31:16], mmio_wstrb[3:2]};
  assign mmio_ready  = 1'b1;
  assign off    = mmio_addr[11:0];
  assign wr_acc = mmio_valid & mmio_we;
  assign rd_acc = mmio_valid & ~mmio_we;
  assign w1c    = wr_acc && (off == UART_STATUS_OFF) && mmio_wstrb[0];

  assign tx_push = wr_acc && (off == UART_TXDATA_OFF) && mmio_wstrb[0];
  assign rx_pop  = rd_acc && (off == UART_RXDATA_OFF) && !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(mmio_wdata[7:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_sh),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= 4'h3;
      baud_div <= DEFAULT_DIV;
    end else if (wr_acc) begin
      if (off == UART_CTRL_OFF && mmio_wstrb[0]) ctrl_r <= mmio_wdata[3:0];
      if (off == UART_BAUDDIV_OFF) begin
        if (mmio_wstrb[0]) baud_div[7:0]  <= mmio_wdata[7:0];
        if (mmio_wstrb[1]) baud_div[15:8] <= mmio_wdata[15:8];
      end
    end
  end

`ifdef UART_LOOPBACK_EN
  logic lb_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lb_r <= 1'b0;
    else if (wr_acc && off == UART_CTRL_OFF && mmio_wstrb[0]) lb_r <= mmio_wdata[CTRL_LOOPBACK];
  end
  assign lb_bit   = lb_r;
  assign uart_txd = lb_r ? 1'b1 : txd_int;
  assign rx_src   = lb_r ? txd_int : uart_rxd;
`else
  assign lb_bit   = 1'b0;
  assign uart_txd = txd_int;
  assign rx_src   = uart_rxd;
`endif

  // Sticky flags: a set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      rx_overrun <= (rx_overrun & ~(w1c & mmio_wdata[ST_RX_OVERRUN])) | (rx_push & rx_full & ~rx_pop);
      frame_err  <= (frame_err  & ~(w1c & mmio_wdata[ST_FRAME_ERR]))  | frame_set;
      tx_drop    <= (tx_drop    & ~(w1c & mmio_wdata[ST_TX_DROP]))    | (tx_push & tx_full & ~tx_pop);
    end
  end

  always_comb begin
    status_v                = '0;
    status_v[ST_TX_FULL]    = tx_full;
    status_v[ST_TX_EMPTY]   = tx_empty;
    status_v[ST_RX_FULL]    = rx_full;
    status_v[ST_RX_EMPTY]   = rx_empty;
    status_v[ST_RX_OVERRUN] = rx_overrun;
    status_v[ST_TX_BUSY]    = (tx_state != UART_IDLE);
    status_v[ST_FRAME_ERR]  = frame_err;
    status_v[ST_TX_DROP]    = tx_drop;
    rd_val = '0;
    case (off)
      UART_RXDATA_OFF:  rd_val = rx_empty ? 32'h8000_0000 : {24'h0, rx_rdata};
      UART_STATUS_OFF:  rd_val = {24'h0, status_v};
      UART_CTRL_OFF:    rd_val = {27'h0, lb_bit, ctrl_r};
      UART_BAUDDIV_OFF: rd_val = {16'h0, baud_div};
      default:          rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mmio_rdata <= '0;
    else if (rd_acc) mmio_rdata <= rd_val;
  end

  assign irq = (ctrl_r[CTRL_RX_IRQ_EN] & ~rx_empty) |
               (ctrl_r[CTRL_TX_IRQ_EN] & tx_empty & (tx_state == UART_IDLE));

  // TX: the divisor is latched at pop so BAUDDIV writes only affect later frames.
  assign tx_go      = ctrl_r[CTRL_TX_EN] & ~tx_empty;
  assign tx_bit_end = (tx_cnt == tx_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= UART_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      UART_IDLE:  if (tx_go) tx_next = UART_START;
      UART_START: if (tx_bit_end) tx_next = UART_DATA;
      UART_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = UART_STOP;
      UART_STOP:  if (tx_bit_end) tx_next = tx_go ? UART_START : UART_IDLE;
      default:    tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    txd_int = 1'b1;
    case (tx_state)
      UART_IDLE:  tx_pop  = tx_go;
      UART_START: txd_int = 1'b0;
      UART_DATA:  txd_int = tx_sh[0];
      UART_STOP:  tx_pop  = tx_bit_end & tx_go;
      default:    txd_int = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_div <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_pop) begin
      tx_sh  <= tx_rdata;
      tx_div <= baud_div;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_state != UART_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= '0;
        if (tx_state == UART_DATA) begin
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // RX: rx_s3 is the previous synchronised sample, used only for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else        {rx_s1, rx_s2, rx_s3} <= {rx_src, rx_s1, rx_s2};
  end

  assign rx_go   = ctrl_r[CTRL_RX_EN] & rx_s3 & ~rx_s2;
  assign rx_samp = (rx_state == UART_START) ? (rx_cnt == {1'b0, rx_div[15:1]}) : (rx_cnt == rx_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= UART_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      UART_IDLE:  if (rx_go) rx_next = UART_START;
      UART_START: if (rx_samp) rx_next = rx_s2 ? UART_IDLE : UART_DATA;
      UART_DATA:  if (rx_samp && rx_bit == 3'd7) rx_next = UART_STOP;
      UART_STOP:  if (rx_samp) rx_next = UART_IDLE;
      default:    rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_push   = 1'b0;
    frame_set = 1'b0;
    rx_shift  = 1'b0;
    case (rx_state)
      UART_DATA: rx_shift = rx_samp;
      UART_STOP: begin
        rx_push   = rx_samp & rx_s2;
        frame_set = rx_samp & ~rx_s2;
      end
      default: rx_shift = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt <= '0;
      rx_div <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (rx_state == UART_IDLE) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      if (rx_go) rx_div <= baud_div;
    end else begin
      rx_cnt <= rx_samp ? '0 : rx_cnt + 1'b1;
      if (rx_shift) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end
  end

  assign tx_state_dbg = tx_state;
  assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph: register map, TX framing, FIFO limits,
// RX framing/errors, async reset; loopback when UART_LOOPBACK_EN is defined.
module tb_uart_mmio_periph;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_valid = 1'b0, mmio_we = 1'b0;
  logic [31:0] mmio_addr = '0, mmio_wdata = '0;
  logic [3:0]  mmio_wstrb = '0;
  logic        mmio_ready;
  logic [31:0] mmio_rdata;
  logic        uart_rxd = 1'b1;
  logic        uart_txd, irq;
  logic [1:0]  tx_state_dbg, rx_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_mmio_periph dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb), .mmio_ready(mmio_ready),
    .mmio_rdata(mmio_rdata), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq),
    .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks: all return 1 time unit after a rising edge
  task automatic mmio_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    mmio_valid = 1'b1; mmio_we = 1'b1; mmio_addr = {20'h0, a}; mmio_wdata = d; mmio_wstrb = s;
    @(posedge clk); #1;
    mmio_valid = 1'b0; mmio_we = 1'b0; mmio_wstrb = '0;
  endtask

  task automatic mmio_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    mmio_valid = 1'b1; mmio_we = 1'b0; mmio_addr = {20'h0, a};
    @(posedge clk); #1;
    mmio_valid = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = fr[b];
      repeat (4) @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Decodes one frame from uart_txd at 4 clocks/bit; wait_n is cycles to start.
  task automatic capture_byte(output logic [7:0] d, output logic ok, output int wait_n);
    wait_n = 0; ok = 1'b0; d = '0;
    while (uart_txd !== 1'b0 && wait_n < 200) begin @(posedge clk); #1; wait_n++; end
    if (uart_txd === 1'b0) begin
      repeat (2) @(posedge clk); #1;
      for (int b = 0; b < 8; b++) begin repeat (4) @(posedge clk); #1; d[b] = uart_txd; end
      repeat (4) @(posedge clk); #1;
      ok = (uart_txd === 1'b1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
    checks++; if (mmio_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mmio_rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (mmio_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mmio_ready); end
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL reset_status: got %h want 0000000a", r); end
    mmio_read(12'h00C, r);
    checks++; if (r !== 32'h03) begin errors++; $display("FAIL reset_ctrl: got %h want 00000003", r); end
    mmio_read(12'h010, r);
    checks++; if (r !== 32'd867) begin errors++; $display("FAIL reset_bauddiv: got %0d want 867", r); end
    mmio_read(12'h004, r);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL reset_rxdata_empty: got %h want 80000000", r); end
    mmio_read(12'h000, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", r); end
    mmio_read(12'h020, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", r); end
  endtask

  task automatic test_tx_frame();
    logic [39:0] obs, exp_v;
    logic [9:0]  fr;
    logic [31:0] r;
    int n;
    mmio_write(12'h010, 32'd3, 4'hF);
    mmio_write(12'h000, 32'h55, 4'h1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 40; c++) exp_v[c] = fr[c/4];
    n = 0;
    while (uart_txd !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 1) begin errors++; $display("FAIL tx_start_latency: got %0d cycles want 1", n); end
    obs = '0;
    for (int c = 0; c < 40; c++) begin
      obs[c] = uart_txd;
      if (c == 39) begin
        checks++; if (tx_state_dbg !== 2'd3) begin errors++; $display("FAIL tx_busy_at_39: state %0d want 3", tx_state_dbg); end
      end
      @(posedge clk); #1;
    end
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL tx_frame_55: got %h want %h", obs, exp_v); end
    checks++; if (tx_state_dbg !== 2'd0) begin errors++; $display("FAIL tx_idle_at_40: state %0d want 0", tx_state_dbg); end
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL tx_done_status: got %h want 0000000a", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0]  d;
    logic        ok, hi;
    int          n;
    mmio_write(12'h00C, 32'h02, 4'h1);
    for (int i = 0; i < 20; i++) begin
      mmio_write(12'h000, 32'(i), 4'h1);
      if (i < 16) exp_q.push_back(8'(i));
    end
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h89) begin errors++; $display("FAIL tx_full_drop_status: got %h want 00000089", r); end
    mmio_write(12'h00C, 32'h03, 4'h1);
    for (int i = 0; i < 16; i++) begin
      capture_byte(d, ok, n);
      checks++; if (ok !== 1'b1 || d !== exp_q[0]) begin errors++; $display("FAIL tx_byte_%0d: got %h ok %b want %h", i, d, ok, exp_q[0]); end
      void'(exp_q.pop_front());
      if (i > 0) begin
        checks++; if (n !== 2) begin errors++; $display("FAIL tx_gap_%0d: start after %0d cycles want 2", i, n); end
      end
    end
    hi = 1'b1;
    for (int c = 0; c < 60; c++) begin hi &= (uart_txd === 1'b1); @(posedge clk); #1; end
    checks++; if (hi !== 1'b1) begin errors++; $display("FAIL tx_no_extra_frame: line went low, want idle high"); end
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h8A) begin errors++; $display("FAIL tx_drained_status: got %h want 0000008a", r); end
    mmio_write(12'h008, 32'h80, 4'h0);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h8A) begin errors++; $display("FAIL w1c_no_strobe: got %h want 0000008a", r); end
    mmio_write(12'h008, 32'h80, 4'h1);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL w1c_tx_drop: got %h want 0000000a", r); end
  endtask

  task automatic test_rx();
    logic [31:0] r;
    mmio_write(12'h00C, 32'h07, 4'h1);
    send_frame(8'hA3, 1'b1);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL rx_status: got %h want 00000002", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b want 1", irq); end
    mmio_read(12'h004, r);
    checks++; if (r !== 32'h0000_00A3) begin errors++; $display("FAIL rx_data_a3: got %h want 000000a3", r); end
    mmio_read(12'h004, r);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL rx_after_pop: got %h want 80000000", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] r;
    send_frame(8'h5A, 1'b0);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h4A) begin errors++; $display("FAIL frame_err_status: got %h want 0000004a", r); end
    mmio_write(12'h008, 32'h40, 4'h1);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL frame_err_clear: got %h want 0000000a", r); end
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h10 + i), 1'b1);
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
    end
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h16) begin errors++; $display("FAIL overrun_status: got %h want 00000016", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL overrun_irq: got %b want 1", irq); end
    for (int i = 0; i < 16; i++) begin
      mmio_read(12'h004, r);
      checks++; if (r !== {24'h0, exp_q[0]}) begin errors++; $display("FAIL rx_keep_%0d: got %h want %h", i, r, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    mmio_read(12'h004, r);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL rx_drained: got %h want 80000000", r); end
    mmio_write(12'h008, 32'h10, 4'h1);
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL overrun_clear: got %h want 0000000a", r); end
  endtask

  task automatic test_regs();
    logic [31:0] r, want;
    mmio_write(12'h010, 32'hABCD_EF12, 4'b0010);
    mmio_read(12'h010, r);
    checks++; if (r !== 32'h0000_EF03) begin errors++; $display("FAIL baud_lane1: got %h want 0000ef03", r); end
    mmio_write(12'h010, 32'h1234_0003, 4'b0011);
    mmio_write(12'h024, 32'hFFFF_FFFF, 4'hF);
    checks++; if (mmio_rdata !== 32'h0000_EF03) begin errors++; $display("FAIL rdata_hold: got %h want 0000ef03", mmio_rdata); end
    mmio_read(12'h010, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL baud_restore: got %h want 00000003", r); end
    mmio_write(12'h00C, 32'h1F, 4'b1110);
    mmio_read(12'h00C, r);
    checks++; if (r !== 32'h07) begin errors++; $display("FAIL ctrl_no_lane0: got %h want 00000007", r); end
    mmio_write(12'h00C, 32'h1F, 4'b0001);
    mmio_read(12'h00C, r);
`ifdef UART_LOOPBACK_EN
    want = 32'h1F;
`else
    want = 32'h0F;
`endif
    checks++; if (r !== want) begin errors++; $display("FAIL ctrl_bit4: got %h want %h", r, want); end
    mmio_write(12'h00C, 32'h0B, 4'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq: got %b want 1", irq); end
    mmio_write(12'h00C, 32'h03, 4'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: got %b want 0", irq); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [31:0] r;
    logic        hi;
    mmio_write(12'h00C, 32'h13, 4'h1);
    mmio_write(12'h000, 32'h7E, 4'h1);
    hi = 1'b1;
    for (int c = 0; c < 60; c++) begin hi &= (uart_txd === 1'b1); @(posedge clk); #1; end
    checks++; if (hi !== 1'b1) begin errors++; $display("FAIL loopback_txd_high: line went low, want held 1"); end
    mmio_read(12'h004, r);
    checks++; if (r !== 32'h7E) begin errors++; $display("FAIL loopback_rx: got %h want 0000007e", r); end
    mmio_write(12'h00C, 32'h03, 4'h1);
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    int n;
    mmio_write(12'h000, 32'h00, 4'h1);
    n = 0;
    while (uart_txd !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL mid_frame_start: txd %b want 0", uart_txd); end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL async_reset_txd: got %b want 1", uart_txd); end
    checks++; if (mmio_rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: got %h want 0", mmio_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mmio_read(12'h008, r);
    checks++; if (r !== 32'h0A) begin errors++; $display("FAIL post_reset_status: got %h want 0000000a", r); end
    mmio_read(12'h00C, r);
    checks++; if (r !== 32'h03) begin errors++; $display("FAIL post_reset_ctrl: got %h want 00000003", r); end
    mmio_read(12'h010, r);
    checks++; if (r !== 32'd867) begin errors++; $display("FAIL post_reset_baud: got %0d want 867", r); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL post_reset_txd: got %b want 1", uart_txd); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_regs();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_periph.md
# uart_mmio_periph

Memory-mapped UART peripheral on the `uart_mmio` port of the SoC MMIO interconnect, in the 4 KB page at `UART_BASE`. It decodes register accesses from the `mmio_if` slave port and buffers TX/RX bytes in FIFOs. It serialises and deserialises 8N1 frames at a programmable baud divisor and raises a level interrupt.

## Interface
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO; power of two, ≥2.
- `DEFAULT_DIV`, 16'd867: reset value of BAUDDIV (clocks per bit minus 1; 115200 baud at 100 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mmio` `mmio_if.slave` (bundle, signals below):
  - `mmio_valid` in 1
  - `mmio_we` in 1
  - `mmio_addr` in `ADDR_W`
  - `mmio_wdata` in 32
  - `mmio_wstrb` in 4
  - `mmio_ready` out 1
  - `mmio_rdata` out 32
- `uart_rxd` in 1: serial input, asynchronous to `clk`.
- `uart_txd` out 1: serial output, idle high.
- `irq` out 1: level interrupt.

## Operation
- Decode uses `mmio_addr[11:0]`. Unmapped offsets read 0; writes to them are ignored.
- **0x00 TXDATA (W):**
  - A write with `wstrb[0]` pushes `wdata[7:0]` into the TX FIFO.
  - If the FIFO is full, the byte is dropped and sticky `tx_drop` is set.
  - Reads return 0.
- **0x04 RXDATA (R):**
  - A read of a non-empty FIFO returns `{24'h0, byte}` and pops it.
  - A read of an empty FIFO returns 0x8000_0000 and does not pop.
  - Writes are ignored.
- **0x08 STATUS:**
  - Read-only bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [5] tx_busy (shifter active).
  - Sticky bits: [4] rx_overrun, [6] frame_err, [7] tx_drop.
  - Sticky bits are write-1-to-clear through `wstrb[0]`.
- **0x0C CTRL (RW):** [0] tx_en, [1] rx_en, [2] rx_irq_en, [3] tx_irq_en, [4] loopback (only under the macro). Byte-lane writes follow `wstrb`.
- **0x10 BAUDDIV (RW):** [15:0]. Byte-lane writes follow `wstrb[1:0]`.
- **TX FSM IDLE → START → DATA → STOP → IDLE:**
  - IDLE: when tx_en and the TX FIFO is non-empty, pop a byte, latch BAUDDIV, go to START.
  - Each bit lasts DIV+1 clocks. Data is sent LSB first; stop bit is 1.
  - At the end of STOP, if the FIFO is non-empty and tx_en is set, go directly to START (no idle gap).
- **RX path:**
  - Input passes through a 2-flop synchroniser.
  - RX FSM IDLE → START → DATA → STOP, entered on a falling edge while rx_en is set.
  - START: sample at DIV/2 clocks; a high sample returns to IDLE (glitch).
  - Data bits are sampled every DIV+1 clocks thereafter.
  - STOP sample 0: set frame_err and discard the byte.
  - STOP sample 1: push the byte. If the RX FIFO is full, drop it and set rx_overrun.
- `irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy)`.

## Timing
- `mmio_ready` is constant 1; every valid access is accepted in its cycle.
- Read data is registered: `mmio_rdata` holds the accepted read's value from the next cycle until the next accepted read. The interconnect samples it exactly one cycle after acceptance.
- Register writes and FIFO pushes/pops take effect at the accepting clock edge. A STATUS read in the following cycle reflects them.
- FIFO push and pop in the same cycle: both happen and the count is unchanged. A push to a full FIFO with a simultaneous pop succeeds.
- A sticky-bit set coinciding with its W1C: the set wins.
- A BAUDDIV write mid-frame affects the next frame only.
- `uart_txd` leaves IDLE on the clock after the pop; the start bit begins that cycle.
- Reset values:
  - `uart_txd`=1, `mmio_rdata`=0, `irq`=0.
  - CTRL=0x03, BAUDDIV=`DEFAULT_DIV`.
  - FIFOs empty, sticky bits 0, both FSMs IDLE.
- Reset asserted mid-frame: `uart_txd` returns to 1 asynchronously and the partial frame is lost.

## Configuration
- `UART_LOOPBACK_EN` defined:
  - CTRL[4] is writable.
  - When set, the RX synchroniser input is the internal TX line instead of `uart_rxd`, and `uart_txd` is held at 1.
- Not defined: CTRL[4] reads 0, writes to it are ignored, and there is no loopback mux.

## Structure
- Shared package `periph_defines`:
  - Register offsets `UART_TXDATA_OFF`..`UART_BAUDDIV_OFF`.
  - STATUS/CTRL bit-index constants.
  - `uart_state_e` typedef (IDLE/START/DATA/STOP), used by both FSMs.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports push/pop/full/empty.
  - Instantiated twice (TX, RX) and reusable by the SPI peripheral.

## Test plan
- BAUDDIV=3, write 0x55 to TXDATA → `uart_txd` shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks; tx_busy drops after 40 clocks.
- Write 20 bytes with tx_en=0 → STATUS reads tx_full=1, tx_drop=1; 16 bytes are transmitted after tx_en=1; W1C 0x80 clears tx_drop.
- Drive frame 0xA3 on `uart_rxd` → STATUS rx_empty=0, `irq`=1 with rx_irq_en; RXDATA reads 0x0000_00A3, then 0x8000_0000.
- Frame with stop bit 0 → frame_err=1, RX FIFO stays empty; 17 frames without reads → rx_overrun=1, 16 bytes retained.
- `UART_LOOPBACK_EN` defined, CTRL=0x13, write 0x7E → RXDATA returns 0x7E and `uart_txd` stays 1.
- Assert `rst_n` mid-TX-frame → `uart_txd`=1 immediately; after release STATUS=0x0A, CTRL=0x03, BAUDDIV=867.
